// File: rtl/stage_sequencer.sv
// Multi-cycle instruction stage sequencer: walks IF/ID/EX/MEM/WB per instruction class,
// with stall freeze, per-stage wait timeout into a sticky HALT, and a retire counter.
module stage_sequencer #(
  parameter int unsigned OP_WIDTH    = 6,
  parameter int unsigned FUNCT_WIDTH = 6,
  parameter int unsigned TIMEOUT     = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OP_WIDTH-1:0]    op_code,
  input  logic [FUNCT_WIDTH-1:0] funct,
  input  logic                   inst_ready,
  input  logic                   mem_ready,
  input  logic                   stall,
  output logic                   if_en,
  output logic                   id_en,
  output logic                   ex_en,
  output logic                   mem_en,
  output logic                   wb_en,
  output logic                   inst_read_en,
  output logic                   mem_req,
  output logic [2:0]             stage,
  output logic                   retired,
  output logic [CNT_W-1:0]       retire_count,
  output logic                   timeout_err
);

  localparam int unsigned WaitW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StIf   = 3'd1,
    StId   = 3'd2,
    StEx   = 3'd3,
    StMem  = 3'd4,
    StWb   = 3'd5,
    StHalt = 3'd7
  } state_e;

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic             store_q, store_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  logic is_rtype, is_load, is_store, is_branch, timeout_hit, waiting;

  // Link jumps (JAL, JALR) and everything unlisted share the plain EX->WB path.
  always_comb begin
    is_rtype  = (op_code == '0);
    is_load   = (op_code >= OP_WIDTH'(32'h20)) && (op_code <= OP_WIDTH'(32'h25));
    is_store  = (op_code == OP_WIDTH'(32'h28)) || (op_code == OP_WIDTH'(32'h29)) ||
                (op_code == OP_WIDTH'(32'h2B));
    is_branch = (op_code == OP_WIDTH'(32'h01)) || (op_code == OP_WIDTH'(32'h02)) ||
                ((op_code >= OP_WIDTH'(32'h04)) && (op_code <= OP_WIDTH'(32'h07))) ||
                (is_rtype && (funct == FUNCT_WIDTH'(32'h08)));
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_q == WaitW'(TIMEOUT));

  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    if_en        = 1'b0;
    id_en        = 1'b0;
    ex_en        = 1'b0;
    mem_en       = 1'b0;
    wb_en        = 1'b0;
    inst_read_en = 1'b0;
    mem_req      = 1'b0;
    retired      = 1'b0;
    waiting      = 1'b0;
    case (state_q)
      StIdle: state_d = StIf;
      StIf: begin
        inst_read_en = 1'b1;
        if (!stall) begin
          if (inst_ready) begin
            if_en   = 1'b1;
            state_d = StId;
          end else if (timeout_hit) begin
            state_d = StHalt;
          end else begin
            waiting = 1'b1;
          end
        end
      end
      StId: begin
        if (!stall) begin
          id_en   = 1'b1;
          state_d = StEx;
        end
      end
      StEx: begin
        if (!stall) begin
          ex_en   = 1'b1;
          store_d = is_store;
          if (is_load || is_store) begin
            state_d = StMem;
          end else if (is_branch) begin
            retired = 1'b1;
            state_d = StIf;
          end else begin
            state_d = StWb;
          end
        end
      end
      StMem: begin
        mem_req = 1'b1;
        if (!stall) begin
          if (mem_ready) begin
            mem_en  = 1'b1;
            retired = store_q;
            state_d = store_q ? StIf : StWb;
          end else if (timeout_hit) begin
            state_d = StHalt;
          end else begin
            waiting = 1'b1;
          end
        end
      end
      StWb: begin
        if (!stall) begin
          wb_en   = 1'b1;
          retired = 1'b1;
          state_d = StIf;
        end
      end
      StHalt: state_d = StHalt;
      default: state_d = StIdle;
    endcase

    // The wait counter restarts whenever the state changes.
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (waiting) begin
      wait_d = wait_q + WaitW'(1);
    end else begin
      wait_d = wait_q;
    end
    cnt_d = cnt_q + CNT_W'(retired);
    err_d = err_q | (state_d == StHalt);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      wait_q  <= '0;
      store_q <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      store_q <= store_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  assign stage        = state_q;
  assign retire_count = cnt_q;
  assign timeout_err  = err_q;

endmodule
